// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: one registered result slot with valid/ready on both sides.
// Branch-compare flags are produced for every operation from a shared subtraction.
module alu_exec_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [XLEN-1:0]  pc,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out,
  output logic             flag_zero,
  output logic             flag_lt,
  output logic             flag_ltu,
  output logic             illegal_op
);

  localparam int SH_W = $clog2(XLEN);

  function automatic logic [XLEN-1:0] alu_op(
    input logic [3:0]      code,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b,
    input logic [XLEN-1:0] pc_v
  );
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [SH_W-1:0]        shamt;
    sa    = a;
    sb    = b;
    shamt = b[SH_W-1:0];
    case (code)
      4'd0:    alu_op = a + b;
      4'd1:    alu_op = a - b;
      4'd2:    alu_op = a ^ b;
      4'd3:    alu_op = a | b;
      4'd4:    alu_op = a & b;
      4'd5:    alu_op = a << shamt;
      4'd6:    alu_op = a >> shamt;
      4'd7:    alu_op = sa >>> shamt;
      4'd8:    alu_op = {{(XLEN-1){1'b0}}, (sa < sb)};
      4'd9:    alu_op = {{(XLEN-1){1'b0}}, (a < b)};
      4'd10:   alu_op = b;
      4'd11:   alu_op = pc_v + b;
      default: alu_op = '0;
    endcase
  endfunction

  // Returns {zero, lt, ltu}; signed lt uses the operand signs when they differ
  // so the subtraction never has to be overflow-corrected.
  function automatic logic [2:0] cmp_flags(
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [XLEN:0] diff;
    logic          lt;
    diff = {1'b0, a} - {1'b0, b};
    lt   = (a[XLEN-1] ^ b[XLEN-1]) ? a[XLEN-1] : diff[XLEN-1];
    cmp_flags = {(diff[XLEN-1:0] == '0), lt, diff[XLEN]};
  endfunction

  logic [XLEN-1:0]  res_p0;
  logic [2:0]       flags_p0;
  logic             ill_p0;
  logic             accept_p0;

  logic             vld_p1;
  logic [XLEN-1:0]  res_p1;
  logic [TAG_W-1:0] tag_p1;
  logic [2:0]       flags_p1;
  logic             ill_p1;

  // ---- stage p0: combinational execute ----
  assign res_p0    = alu_op(alu_control, op_a, op_b, pc);
  assign flags_p0  = cmp_flags(op_a, op_b);
  assign ill_p0    = alu_control[3] & alu_control[2];
  assign in_ready  = !vld_p1 || out_ready;
  assign accept_p0 = in_valid && in_ready;

  // ---- stage p1: output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      res_p1   <= '0;
      tag_p1   <= '0;
      flags_p1 <= '0;
      ill_p1   <= 1'b0;
    end else if (flush) begin
      vld_p1   <= 1'b0;
    end else if (accept_p0) begin
      vld_p1   <= 1'b1;
      res_p1   <= res_p0;
      tag_p1   <= tag_in;
      flags_p1 <= flags_p0;
      ill_p1   <= ill_p0;
    end else if (out_ready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign out_valid  = vld_p1;
  assign result     = res_p1;
  assign tag_out    = tag_p1;
  assign flag_zero  = flags_p1[2];
  assign flag_lt    = flags_p1[1];
  assign flag_ltu   = flags_p1[0];
  assign illegal_op = ill_p1;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: expectations queued on accept,
// popped and compared when a result is handed downstream.
module tb_alu_exec_stage;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  typedef struct packed {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    logic             z;
    logic             lt;
    logic             ltu;
    logic             ill;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       alu_control = '0;
  logic [XLEN-1:0]  op_a = '0;
  logic [XLEN-1:0]  op_b = '0;
  logic [XLEN-1:0]  pc = '0;
  logic [TAG_W-1:0] tag_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_out;
  logic             flag_zero;
  logic             flag_lt;
  logic             flag_ltu;
  logic             illegal_op;

  int   total = 0;
  int   bad = 0;
  bit   rand_mode = 1'b0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [XLEN-1:0] r1;

  alu_exec_stage #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .op_a(op_a), .op_b(op_b), .pc(pc), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .tag_out(tag_out),
    .flag_zero(flag_zero), .flag_lt(flag_lt), .flag_ltu(flag_ltu),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] code, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] p,
                                 input logic [4:0] tag);
    exp_t e;
    int   sh;
    sh    = int'(b[4:0]);
    e.tag = tag;
    e.ill = 1'b0;
    case (code)
      4'd0:  e.res = a + b;
      4'd1:  e.res = a - b;
      4'd2:  e.res = a ^ b;
      4'd3:  e.res = a | b;
      4'd4:  e.res = a & b;
      4'd5:  e.res = a << sh;
      4'd6:  e.res = a >> sh;
      4'd7:  e.res = $unsigned($signed(a) >>> sh);
      4'd8:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  e.res = (a < b) ? 32'd1 : 32'd0;
      4'd10: e.res = b;
      4'd11: e.res = p + b;
      default: begin e.res = '0; e.ill = 1'b1; end
    endcase
    e.z   = (a == b);
    e.lt  = ($signed(a) < $signed(b));
    e.ltu = (a < b);
    return e;
  endfunction

  // Holds the op on the inputs until it is accepted; the expectation is queued
  // at the negedge before the accepting edge.
  task automatic send(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, input logic [4:0] tag,
                      input logic [31:0] exp_res, input bit use_exp);
    exp_t e;
    bit   acc;
    int   n;
    e = model(code, a, b, p, tag);
    if (use_exp) e.res = exp_res;
    in_valid = 1'b1; alu_control = code; op_a = a; op_b = b; pc = p; tag_in = tag;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = in_ready && !flush;
      if (acc) sb_q.push_back(e);
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (sb_q.size() == 0) begin
        check("extra_output", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("res", result, mon_e.res);
        check("tag", tag_out, mon_e.tag);
        check("zero", flag_zero, mon_e.z);
        check("lt", flag_lt, mon_e.lt);
        check("ltu", flag_ltu, mon_e.ltu);
        check("illegal", illegal_op, mon_e.ill);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb, rp;
    logic [3:0]  rc;

    // reset with a pending request
    rst_n = 1'b0; in_valid = 1'b1; op_a = 32'd5; op_b = 32'd6;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", out_valid, 0);
    check("rst_res", result, 0);
    check("rst_tag", tag_out, 0);
    check("rst_flags", {flag_zero, flag_lt, flag_ltu, illegal_op}, 0);
    check("rst_rdy", in_ready, 1);
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed operations
    send(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd1, 32'h0000_0000, 1);
    check("lat_vld", out_valid, 1);
    check("lat_res", result, 32'h0);
    send(4'd1,  32'hFFFF_FFFF, 32'd1,        32'd0,      5'd2,  32'hFFFF_FFFE, 1);
    send(4'd7,  32'h8000_0000, 32'h21,       32'd0,      5'd3,  32'hC000_0000, 1);
    send(4'd6,  32'h8000_0000, 32'h21,       32'd0,      5'd4,  32'h4000_0000, 1);
    send(4'd5,  32'h0000_0001, 32'h21,       32'd0,      5'd5,  32'h0000_0002, 1);
    send(4'd8,  32'hFFFF_FFFF, 32'd1,        32'd0,      5'd6,  32'h0000_0001, 1);
    send(4'd9,  32'hFFFF_FFFF, 32'd1,        32'd0,      5'd7,  32'h0000_0000, 1);
    send(4'd11, 32'd0,         32'h2000,     32'h1000,   5'd8,  32'h0000_3000, 1);
    send(4'd13, 32'd5,         32'd6,        32'd0,      5'd9,  32'h0000_0000, 1);
    send(4'd10, 32'd0,         32'h1234_5000, 32'd0,     5'd10, 32'h1234_5000, 1);
    send(4'd1,  32'd77,        32'd77,       32'd0,      5'd11, 32'h0000_0000, 1);
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", sb_q.size(), 0);
    check("drain_vld", out_valid, 0);

    // backpressure with three back-to-back ops
    out_ready = 1'b0;
    send(4'd0, 32'd10, 32'd20, 32'd0, 5'd11, 32'd30, 1);
    r1 = result;
    check("bp_first_vld", out_valid, 1);
    fork
      begin
        send(4'd1, 32'd100, 32'd1, 32'd0, 5'd12, 32'd99, 1);
        send(4'd2, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);
      end
      begin
        repeat (2) begin
          @(negedge clk);
          check("stall_rdy", in_ready, 0);
          check("hold_res", result, r1);
          check("hold_tag", tag_out, 11);
          check("hold_vld", out_valid, 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("bp_empty", sb_q.size(), 0);

    // flush while a result is held
    out_ready = 1'b0;
    send(4'd3, 32'd1, 32'd2, 32'd0, 5'd20, 32'd3, 1);
    check("fl_pre_vld", out_valid, 1);
    flush = 1'b1; in_valid = 1'b1; alu_control = 4'd0; op_a = 32'd7; op_b = 32'd7; tag_in = 5'd21;
    @(negedge clk);
    check("fl_rdy", in_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check("fl_vld", out_valid, 0);
    check("fl_q", sb_q.size(), 1);
    sb_q.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("fl_post_vld", out_valid, 0);

    // flush beats an accept on an empty stage
    flush = 1'b1; in_valid = 1'b1; alu_control = 4'd0; op_a = 32'd1; op_b = 32'd1; tag_in = 5'd22;
    @(negedge clk);
    check("fl2_rdy", in_ready, 1);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check("fl2_vld", out_valid, 0);

    // asynchronous reset mid-operation
    out_ready = 1'b0;
    send(4'd0, 32'd3, 32'd4, 32'd0, 5'd23, 32'd7, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_vld", out_valid, 0);
    check("arst_res", result, 0);
    sb_q.delete();
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // random ops under random backpressure
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = $urandom();
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom();
      rp = $urandom();
      send(rc, ra, rb, rp, 5'(i), 32'd0, 0);
    end
    @(posedge clk);
    #1 rand_mode = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rand_empty", sb_q.size(), 0);
    check("rand_vld", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage ALU that consumes the 4-bit alu_control code from the ALU decoder and produces a registered result plus branch-compare flags.
- Sits between decode/issue and memory/writeback in the RV32IMF core.
- Uses a valid/ready handshake on both sides.
- A single output register holds a result until downstream accepts it.
- Flush kills the in-flight result.

Parameters:
- XLEN, 32, datapath width; shift amount uses low log2(XLEN) bits of operand b.
- TAG_W, 5, width of the destination-register tag carried alongside the result.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of output register (branch mispredict/trap)
- in_valid  input  1  issue side has a valid operation
- in_ready  output  1  stage can accept an operation this cycle
- alu_control  input  4  operation code (encoding below)
- op_a  input  XLEN  rs1 value
- op_b  input  XLEN  rs2 value or immediate (U-immediate for LUI/AUIPC)
- pc  input  XLEN  instruction address (AUIPC)
- tag_in  input  TAG_W  destination register index
- out_valid  output  1  result register holds a valid result
- out_ready  input  1  downstream accepts the result this cycle
- result  output  XLEN  registered result
- tag_out  output  TAG_W  registered destination tag
- flag_zero  output  1  registered: (op_a - op_b) == 0
- flag_lt  output  1  registered: signed op_a < op_b
- flag_ltu  output  1  registered: unsigned op_a < op_b
- illegal_op  output  1  registered: code was 12..15

Behaviour:
- Reset (rst_n low, async): out_valid=0, result=0, tag_out=0, all flags=0, illegal_op=0. in_ready is 1 while in reset deasserted with out_valid=0.
- Code encoding:
  - 0 ADD a+b; 1 SUB a-b; 2 XOR; 3 OR; 4 AND
  - 5 SLL a<<b[4:0]; 6 SRL logical; 7 SRA arithmetic (sign-fill)
  - 8 SLT signed compare → {0..,1}/0; 9 SLTU unsigned compare
  - 10 LUI result=op_b; 11 AUIPC result=pc+op_b
  - 12..15: result=0, illegal_op=1
- Arithmetic wraps modulo 2^XLEN; no exceptions on overflow.
- in_ready = !out_valid || out_ready (combinational; no dependency on in_valid).
- Accept: in_valid && in_ready on a rising edge loads result, tag_out, flags and illegal_op; out_valid=1 next cycle. Latency 1 cycle.
- Hold: out_valid && !out_ready → result, tag, flags and out_valid held stable; in_ready=0; inputs ignored.
- Drain: out_ready && out_valid && !in_valid → out_valid=0 next cycle; result/flags keep last value (don't care).
- Simultaneous drain and accept: the new op loads, out_valid stays 1, and throughput is 1 op/cycle.
- Flags are computed for every code (subtraction of op_a and op_b), independent of alu_control.
- flush has priority over accept:
  - out_valid=0 next cycle; the op presented that cycle is discarded.
  - in_ready is still driven per the formula; upstream must squash its own op.
- Reset mid-operation: pending result is lost immediately; out_valid=0 asynchronously.
- out_valid never depends combinationally on out_ready.

Test Plan:
- Reset: hold rst_n=0, drive in_valid=1 → out_valid=0, result=0; release → first accepted op appears 1 cycle later.
- ADD/SUB wrap: a=0xFFFFFFFF, b=1, code 0 → result 0x00000000, flag_zero=0, flag_ltu=0. Same operands with code 1 → result 0xFFFFFFFE.
- Shifts: a=0x80000000, b=0x00000021.
  - code 7 → 0xC0000000 (shift 1)
  - code 6 → 0x40000000
  - code 5 with a=1 → 0x00000002
- Compares and U-type:
  - a=0xFFFFFFFF, b=1: code 8 → 1, code 9 → 0, flag_lt=1, flag_ltu=0
  - code 11, pc=0x1000, b=0x00002000 → 0x00003000
  - code 13 → result 0, illegal_op=1
- Backpressure: issue 3 back-to-back ops with out_ready=0 for 2 cycles.
  - in_ready=0 during the stall.
  - First result held stable.
  - All 3 results delivered in order with correct tags; no drop or duplicate.
- Flush: out_valid=1, assert flush with in_valid=1 → out_valid=0 next cycle and the flushed-cycle op never appears on the output.
